nrisc_ddata_arbiter: RTL and testbench
======================================

Name: nrisc_ddata_arbiter

Overview:
- Shares the single D-Data memory port between two requesters:
  - the NRISC_UP core (port C);
  - an auxiliary master (port X), such as DMA or a debug unit.
- Fixed core priority with an anti-starvation counter for X.
- One access in flight at a time. Sequences the memory strobe, waits out read latency, and returns read data to the owner.
- Sits between NRISC_UP's DDATA_CORE_* bus and the data memory.

Parameters:
TAM, 16, data width (matches core TAM)
N_DData, 16, D-Data address width
MEM_LAT, 2, cycles from mem_load strobe cycle to mem_out valid (legal range 1..15)
STARVE_LIM, 3, consecutive X losses before X is forced to win (legal range 1..15)

Ports:
clk  in  1  main clock
rst  in  1  asynchronous, active-high reset
c_req  in  1  core request; held stable until c_gnt
c_load  in  1  core read
c_write  in  1  core write
c_ctrl  in  3  core size ctrl (passed through)
c_addr  in  N_DData  core address
c_wdata  in  TAM  core write data
c_gnt  out  1  one-cycle pulse: core access accepted
c_rvalid  out  1  one-cycle pulse: c_rdata valid
c_rdata  out  TAM  core read data
x_req, x_load, x_write, x_ctrl, x_addr, x_wdata  in  (same widths as core)  aux request fields
x_gnt, x_rvalid  out  1  aux equivalents
x_rdata  out  TAM  aux read data
mem_addr  out  N_DData  memory address
mem_in  out  TAM  memory write data
mem_load  out  1  read strobe
mem_write  out  1  write strobe
mem_ctrl  out  3  size ctrl
mem_out  in  TAM  memory read data
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: async, active-high. All outputs 0, state IDLE, starve_cnt 0, owner C, latency counter 0.
  - Reset mid-access aborts the access. No gnt or rvalid is produced for it.
- Request qualification:
  - A request is valid only if req is high and load|write is high.
  - req with neither load nor write is ignored.
  - load and write both high is treated as a write.
- States: IDLE, STROBE, WAIT, RESP.
- IDLE, cycle T: arbitration is combinational and is committed at the T edge.
  - Winner is C if C is valid and not (X valid and starve_cnt==STARVE_LIM); otherwise X if X is valid.
  - On a winner: latch addr, wdata, ctrl and op into mem_* registers, set owner, go to STROBE.
  - If both valid and C wins: starve_cnt+1, saturating at STARVE_LIM.
  - If X wins: starve_cnt=0.
  - If only C is valid: starve_cnt unchanged.
- STROBE, cycle T+1:
  - Exactly one of mem_load or mem_write is 1.
  - Owner's gnt=1; this is the only cycle gnt is high.
  - Write: next state IDLE.
  - Read: counter=MEM_LAT-1; next state WAIT, or RESP directly when MEM_LAT==1.
- WAIT:
  - Strobes 0; mem_addr and mem_ctrl held.
  - Counter decrements; go to RESP when it reaches 0 (after MEM_LAT-1 cycles in WAIT).
- RESP, cycle T+MEM_LAT+1:
  - mem_out is sampled into owner's rdata register at the end of this cycle.
  - Next state IDLE.
- IDLE entry after a read: owner's rvalid=1 for that cycle, with rdata = captured value.
  - Arbitration for the next access happens in that same cycle.
- rdata registers hold their value until the next read for the same port.
- Non-owner outputs (gnt, rvalid) stay 0 throughout an access.
- Latency: write occupies 2 cycles (IDLE→STROBE). Read: rvalid arrives MEM_LAT+2 cycles after the arbitration cycle.
- Once arbitrated, an access completes even if req drops. The requester must deassert req in or after its gnt cycle; if req is still high in the next IDLE cycle, it is a new request.
- Requests arriving while busy wait. There is no queue; the req line itself is the pending state.
- mem_addr, mem_in and mem_ctrl are registered. They change only on arbitration and hold their last value in IDLE.

Test Plan:
- Reset release, C write addr 0x0010 data 0xBEEF at T (idle) -> T+1: mem_write=1, mem_addr=0x0010, mem_in=0xBEEF, c_gnt=1; T+2: busy=0.
- C read addr 0x0020, memory returns 0x1234 at strobe+2 (MEM_LAT=2) -> mem_load high only at T+1; c_rvalid=1 with c_rdata=0x1234 at T+4; x_rvalid stays 0.
- C and X requesting continuously (STARVE_LIM=3) -> grant order C,C,C,X,C,C,C,X; starve_cnt reads 0 after each X grant.
- X only, read 0x0040 -> x_gnt at T+1, x_rvalid at T+4; starve_cnt unchanged at 0.
- rst asserted in WAIT of a read -> all outputs 0 immediately; after release, no rvalid; next C request is served normally.
- c_req with load=write=1 -> mem_write=1, mem_load=0; c_req with load=write=0 -> no grant, busy stays 0.

Source files
------------

// File: rtl/nrisc_ddata_arbiter.sv
// Two-master arbiter for the NRISC_UP D-Data memory port: core (C) has fixed priority,
// auxiliary master (X) is forced through after STARVE_LIM consecutive losses.
module nrisc_ddata_arbiter #(
    parameter int TAM        = 16,
    parameter int N_DData    = 16,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_LIM = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               c_req,
    input  logic               c_load,
    input  logic               c_write,
    input  logic [2:0]         c_ctrl,
    input  logic [N_DData-1:0] c_addr,
    input  logic [TAM-1:0]     c_wdata,
    output logic               c_gnt,
    output logic               c_rvalid,
    output logic [TAM-1:0]     c_rdata,
    input  logic               x_req,
    input  logic               x_load,
    input  logic               x_write,
    input  logic [2:0]         x_ctrl,
    input  logic [N_DData-1:0] x_addr,
    input  logic [TAM-1:0]     x_wdata,
    output logic               x_gnt,
    output logic               x_rvalid,
    output logic [TAM-1:0]     x_rdata,
    output logic [N_DData-1:0] mem_addr,
    output logic [TAM-1:0]     mem_in,
    output logic               mem_load,
    output logic               mem_write,
    output logic [2:0]         mem_ctrl,
    input  logic [TAM-1:0]     mem_out,
    output logic               busy
);

    typedef enum logic [1:0] {S_IDLE, S_STROBE, S_WAIT, S_RESP} state_t;

    localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM);

    state_t               state_reg, state_next;
    logic                 owner_x_reg;
    logic                 op_write_reg;
    logic [3:0]           lat_cnt_reg;
    logic [3:0]           starve_cnt_reg;
    logic [N_DData-1:0]   addr_reg;
    logic [TAM-1:0]       wdata_reg;
    logic [2:0]           ctrl_reg;
    logic [TAM-1:0]       c_rdata_reg, x_rdata_reg;
    logic                 c_rvalid_reg, x_rvalid_reg;

    logic c_valid, x_valid, c_wins, x_wins;

    always_comb begin
        c_valid = c_req & (c_load | c_write);
        x_valid = x_req & (x_load | x_write);
        // X is forced through once it has lost STARVE_LIM times in a row
        c_wins  = (state_reg == S_IDLE) && c_valid &&
                  !(x_valid && (starve_cnt_reg == STARVE_MAX));
        x_wins  = (state_reg == S_IDLE) && x_valid && !c_wins;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (c_wins || x_wins) state_next = S_STROBE;
            S_STROBE: begin
                if (op_write_reg)       state_next = S_IDLE;
                else if (MEM_LAT == 1)  state_next = S_RESP;
                else                    state_next = S_WAIT;
            end
            S_WAIT:   if (lat_cnt_reg == 4'd1) state_next = S_RESP;
            S_RESP:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            owner_x_reg    <= 1'b0;
            op_write_reg   <= 1'b0;
            lat_cnt_reg    <= '0;
            starve_cnt_reg <= '0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            ctrl_reg       <= '0;
            c_rdata_reg    <= '0;
            x_rdata_reg    <= '0;
            c_rvalid_reg   <= 1'b0;
            x_rvalid_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;

            if (c_wins || x_wins) begin
                owner_x_reg  <= x_wins;
                // load and write together count as a write
                op_write_reg <= x_wins ? x_write : c_write;
                addr_reg     <= x_wins ? x_addr  : c_addr;
                wdata_reg    <= x_wins ? x_wdata : c_wdata;
                ctrl_reg     <= x_wins ? x_ctrl  : c_ctrl;
            end

            if (x_wins)
                starve_cnt_reg <= '0;
            else if (c_wins && x_valid && starve_cnt_reg != STARVE_MAX)
                starve_cnt_reg <= starve_cnt_reg + 4'd1;

            if (state_reg == S_STROBE && !op_write_reg)
                lat_cnt_reg <= LAT_INIT;
            else if (state_reg == S_WAIT)
                lat_cnt_reg <= lat_cnt_reg - 4'd1;

            if (state_reg == S_RESP) begin
                if (owner_x_reg) x_rdata_reg <= mem_out;
                else             c_rdata_reg <= mem_out;
            end

            // rvalid is registered so it lands on the IDLE cycle after RESP
            c_rvalid_reg <= (state_reg == S_RESP) && !owner_x_reg;
            x_rvalid_reg <= (state_reg == S_RESP) &&  owner_x_reg;
        end
    end

    always_comb begin
        busy      = (state_reg != S_IDLE);
        mem_load  = (state_reg == S_STROBE) && !op_write_reg;
        mem_write = (state_reg == S_STROBE) &&  op_write_reg;
        c_gnt     = (state_reg == S_STROBE) && !owner_x_reg;
        x_gnt     = (state_reg == S_STROBE) &&  owner_x_reg;
        mem_addr  = addr_reg;
        mem_in    = wdata_reg;
        mem_ctrl  = ctrl_reg;
        c_rvalid  = c_rvalid_reg;
        x_rvalid  = x_rvalid_reg;
        c_rdata   = c_rdata_reg;
        x_rdata   = x_rdata_reg;
    end

endmodule

// File: tb/tb_nrisc_ddata_arbiter.sv
// Directed bench for nrisc_ddata_arbiter with a two-cycle-latency memory model.
module tb_nrisc_ddata_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, c_load, c_write;
    logic [2:0]  c_ctrl;
    logic [15:0] c_addr, c_wdata;
    logic        c_gnt, c_rvalid;
    logic [15:0] c_rdata;
    logic        x_req, x_load, x_write;
    logic [2:0]  x_ctrl;
    logic [15:0] x_addr, x_wdata;
    logic        x_gnt, x_rvalid;
    logic [15:0] x_rdata;
    logic [15:0] mem_addr, mem_in;
    logic        mem_load, mem_write;
    logic [2:0]  mem_ctrl;
    logic [15:0] mem_out;
    logic        busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    nrisc_ddata_arbiter #(.TAM(16), .N_DData(16), .MEM_LAT(2), .STARVE_LIM(3)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_load(c_load), .c_write(c_write), .c_ctrl(c_ctrl),
        .c_addr(c_addr), .c_wdata(c_wdata), .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .x_req(x_req), .x_load(x_load), .x_write(x_write), .x_ctrl(x_ctrl),
        .x_addr(x_addr), .x_wdata(x_wdata), .x_gnt(x_gnt), .x_rvalid(x_rvalid), .x_rdata(x_rdata),
        .mem_addr(mem_addr), .mem_in(mem_in), .mem_load(mem_load), .mem_write(mem_write),
        .mem_ctrl(mem_ctrl), .mem_out(mem_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory model: data valid two cycles after the strobe cycle.
    function automatic logic [15:0] mem_data(input logic [15:0] a);
        if (a == 16'h0020)      return 16'h1234;
        else if (a == 16'h0040) return 16'hA5A5;
        else                    return {8'hD0, a[7:0]};
    endfunction

    logic [15:0] pipe0 = '0;
    logic [15:0] pipe1 = '0;
    always @(posedge clk) begin
        if (mem_load) pipe0 <= mem_data(mem_addr);
        pipe1 <= pipe0;
    end
    assign mem_out = pipe1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    logic [7:0] exp_order;
    int         ngr;
    logic       seen;

    initial begin
        rst = 1'b1;
        c_req = 0; c_load = 0; c_write = 0; c_ctrl = 0; c_addr = 0; c_wdata = 0;
        x_req = 0; x_load = 0; x_write = 0; x_ctrl = 0; x_addr = 0; x_wdata = 0;
        repeat (2) tick();
        chk("rst_busy", busy, 0);
        chk("rst_gnt", {c_gnt, x_gnt}, 0);
        chk("rst_strobes", {mem_load, mem_write}, 0);
        chk("rst_rvalid", {c_rvalid, x_rvalid}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_starve", dut.starve_cnt_reg, 0);
        rst = 1'b0;
        tick();

        // C write 0x0010 <- 0xBEEF
        c_req = 1; c_write = 1; c_addr = 16'h0010; c_wdata = 16'hBEEF; c_ctrl = 3'd1;
        tick();
        chk("wr_mem_write", mem_write, 1);
        chk("wr_mem_load", mem_load, 0);
        chk("wr_mem_addr", mem_addr, 16'h0010);
        chk("wr_mem_in", mem_in, 16'hBEEF);
        chk("wr_mem_ctrl", mem_ctrl, 3'd1);
        chk("wr_gnt", {c_gnt, x_gnt}, 2'b10);
        c_req = 0;
        tick();
        chk("wr_busy_done", busy, 0);
        chk("wr_addr_hold", mem_addr, 16'h0010);

        // C read 0x0020, expecting 0x1234 at T+4
        c_req = 1; c_write = 0; c_load = 1; c_addr = 16'h0020; c_ctrl = 3'd2;
        tick();
        chk("rd_strobe", {mem_load, mem_write, c_gnt}, 3'b101);
        chk("rd_mem_addr", mem_addr, 16'h0020);
        c_req = 0;
        tick();
        chk("rd_t2", {mem_load, busy, c_gnt, c_rvalid}, 4'b0100);
        tick();
        chk("rd_t3", {mem_load, busy, c_rvalid, x_rvalid}, 4'b0100);
        tick();
        chk("rd_t4_rvalid", {c_rvalid, x_rvalid, busy}, 3'b100);
        chk("rd_t4_rdata", c_rdata, 16'h1234);
        tick();
        chk("rd_t5_rvalid", c_rvalid, 0);
        chk("rd_t5_hold", c_rdata, 16'h1234);

        // both masters requesting writes back to back
        exp_order = 8'b1000_1000;
        c_req = 1; c_load = 0; c_write = 1; c_addr = 16'h0080; c_wdata = 16'h1111;
        x_req = 1; x_load = 0; x_write = 1; x_addr = 16'h0090; x_wdata = 16'h2222;
        ngr = 0;
        for (int cyc = 0; cyc < 40 && ngr < 8; cyc++) begin
            tick();
            if (c_gnt || x_gnt) begin
                chk($sformatf("arb_grant%0d_is_x", ngr), {c_gnt, x_gnt},
                    exp_order[ngr] ? 2'b01 : 2'b10);
                if (x_gnt) chk($sformatf("arb_starve_after_x%0d", ngr), dut.starve_cnt_reg, 0);
                ngr++;
                if (ngr == 8) begin
                    c_req = 0; x_req = 0;
                end
            end
        end
        chk("arb_grant_count", ngr, 8);
        tick();
        chk("arb_idle", busy, 0);

        // X only read 0x0040
        x_req = 1; x_load = 1; x_write = 0; x_addr = 16'h0040;
        tick();
        chk("x_gnt", {c_gnt, x_gnt, mem_load}, 3'b011);
        x_req = 0;
        tick();
        tick();
        tick();
        chk("x_rvalid", {c_rvalid, x_rvalid}, 2'b01);
        chk("x_rdata", x_rdata, 16'hA5A5);
        chk("x_starve", dut.starve_cnt_reg, 0);
        chk("x_c_rdata_hold", c_rdata, 16'h1234);

        // reset during WAIT aborts the read
        c_req = 1; c_load = 1; c_write = 0; c_addr = 16'h0020;
        tick();
        chk("abort_gnt", c_gnt, 1);
        c_req = 0;
        tick();
        chk("abort_wait_busy", busy, 1);
        rst = 1;
        #1;
        chk("abort_outputs", {busy, c_gnt, x_gnt, mem_load, mem_write, c_rvalid, x_rvalid}, 0);
        chk("abort_regs", {mem_addr, c_rdata}, 0);
        tick();
        rst = 0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen = seen | c_rvalid | x_rvalid;
        end
        chk("abort_no_rvalid", seen, 0);
        c_req = 1; c_load = 0; c_write = 1; c_addr = 16'h0055; c_wdata = 16'h7777;
        tick();
        chk("post_rst_write", {c_gnt, mem_write, mem_addr}, {2'b11, 16'h0055});
        c_req = 0;
        tick();
        chk("post_rst_idle", busy, 0);

        // load+write counts as write; neither is ignored
        c_req = 1; c_load = 1; c_write = 1; c_addr = 16'h0066;
        tick();
        chk("both_ops_write", {mem_write, mem_load, c_gnt}, 3'b101);
        c_req = 0;
        tick();
        c_req = 1; c_load = 0; c_write = 0;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen = seen | busy | c_gnt;
        end
        chk("no_op_ignored", seen, 0);
        c_req = 0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
